// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file definitions: default geometry and the init/run state encoding.
package regfile_scoreboard_pkg;

    localparam int RF_DATA_W   = 16;
    localparam int RF_NUM_REGS = 16;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard_rf_scoreboard.sv
// Pending-write tracker: one busy bit per register plus a registered popcount.
module rf_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                run,
    input  logic                wr_valid,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic                alloc_en,
    input  logic [ADDR_W-1:0]   alloc_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic                alloc_ok,
    output logic [ADDR_W:0]     pend_cnt
);

    localparam int CNT_W = ADDR_W + 1;

    logic [NUM_REGS-1:0] busy_reg, busy_next;
    logic [CNT_W-1:0]    pend_reg, pend_next;
    logic                clr_wr;

    // A same-cycle write to the requested register frees it, so the reservation may proceed.
    assign alloc_ok = alloc_en && run && (alloc_addr != '0) &&
                      (!busy_reg[alloc_addr] || (wr_valid && (waddr == alloc_addr)));
    assign clr_wr   = wr_valid && busy_reg[waddr];

    always_comb begin
        busy_next = busy_reg;
        pend_next = pend_reg;
        if (clear) begin
            busy_next = '0;
            pend_next = '0;
        end else begin
            if (clr_wr)   busy_next[waddr]      = 1'b0;
            if (alloc_ok) busy_next[alloc_addr] = 1'b1;
            if (alloc_ok && !clr_wr)
                pend_next = pend_reg + CNT_W'(1);
            else if (!alloc_ok && clr_wr)
                pend_next = pend_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
            pend_reg <= '0;
        end else begin
            busy_reg <= busy_next;
            pend_reg <= pend_next;
        end
    end

    assign busy     = busy_reg;
    assign pend_cnt = pend_reg;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with zero register, write-through bypass, self-zeroing init sweep
// and a reservation scoreboard for destination registers.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter  int DATA_W   = RF_DATA_W,
    parameter  int NUM_REGS = RF_NUM_REGS,
    parameter  int NUM_RD   = 2,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    output logic                     ready,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic                     alloc_ok,
    output logic [ADDR_W:0]          pend_cnt
);

    rf_state_e           state_reg, state_next;
    logic [ADDR_W-1:0]   cnt_reg, cnt_next;
    logic                wr_valid;
    logic [NUM_REGS-1:0] busy;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem [NUM_REGS];

    assign ready    = (state_reg == RUN);
    assign wr_valid = we && ready && (waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            INIT: begin
                if (clear) begin
                    cnt_next = '0;
                end else if (cnt_reg == ADDR_W'(NUM_REGS - 1)) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + ADDR_W'(1);
                end
            end
            RUN: begin
                if (clear) begin
                    state_next = INIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = INIT;
                cnt_next   = '0;
            end
        endcase
    end

    // One shared write port: the init sweep owns it until the file is ready.
    assign mem_we    = !ready || wr_valid;
    assign mem_waddr = ready ? waddr : cnt_reg;
    assign mem_wdata = ready ? wdata : '0;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : gen_rd
            logic [ADDR_W-1:0] ra;
            logic              hit;

            assign ra  = rd_addr[gi*ADDR_W +: ADDR_W];
            assign hit = wr_valid && (waddr == ra);

            assign rd_data[gi*DATA_W +: DATA_W] = (!ready || (ra == '0)) ? '0 :
                                                  hit ? wdata : mem[ra];
            assign rd_busy[gi] = ready && !hit && busy[ra];
        end
    endgenerate

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .run        (ready),
        .wr_valid   (wr_valid),
        .waddr      (waddr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy       (busy),
        .alloc_ok   (alloc_ok),
        .pend_cnt   (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: expectations are queued as stimulus is driven
// and compared on the falling edge, when the combinational outputs have settled.
module tb_regfile_scoreboard;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int NP = 2;
    localparam int AW = 4;

    localparam int K_RD0   = 0;
    localparam int K_RD1   = 1;
    localparam int K_BUSY0 = 2;
    localparam int K_BUSY1 = 3;
    localparam int K_OK    = 4;
    localparam int K_PEND  = 5;
    localparam int K_READY = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             ready;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*DW-1:0] rd_data;
    logic [NP-1:0]    rd_busy;
    logic             alloc_en;
    logic [AW-1:0]    alloc_addr;
    logic             alloc_ok;
    logic [AW:0]      pend_cnt;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   txn      = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .NUM_RD   (NP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .ready      (ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .alloc_ok   (alloc_ok),
        .pend_cnt   (pend_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_RD0:   return 32'(rd_data[DW-1:0]);
            K_RD1:   return 32'(rd_data[2*DW-1:DW]);
            K_BUSY0: return 32'(rd_busy[0]);
            K_BUSY1: return 32'(rd_busy[1]);
            K_OK:    return 32'(alloc_ok);
            K_PEND:  return 32'(pend_cnt);
            default: return 32'(ready);
        endcase
    endfunction

    task automatic expect_out(input string tag, input int kind, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic cyc_begin();
        @(posedge clk);
        #1;
        we = 1'b0; waddr = '0; wdata = '0;
        alloc_en = 1'b0; alloc_addr = '0; clear = 1'b0;
        rd_addr = '0;
    endtask

    task automatic cyc_end();
        exp_t e;
        @(negedge clk);
        txn++;
        $display("txn %0d: we=%0b waddr=%0d wdata=%04h alloc=%0b@%0d clear=%0b rd=%02h -> rd_data=%08h busy=%0b ok=%0b pend=%0d",
                 txn, we, waddr, wdata, alloc_en, alloc_addr, clear, rd_addr,
                 rd_data, rd_busy, alloc_ok, pend_cnt);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq(e.tag, observe(e.kind), e.val);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, 32'(n), 32'd16);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear = 1'b0; we = 1'b1; waddr = 4'd3; wdata = 16'hFFFF;
        alloc_en = 1'b1; alloc_addr = 4'd5; rd_addr = 8'h21;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_pend", 32'(pend_cnt), 32'd0);
        check_eq("rst_rd", 32'(rd_data), 32'd0);
        check_eq("rst_ok", 32'(alloc_ok), 32'd0);
        we = 1'b0; alloc_en = 1'b0;

        // Scenario 1: sweep length and all-zero contents
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("init_cycles");
        for (int i = 0; i < NR; i++) begin
            cyc_begin();
            rd_addr = {4'(NR - 1 - i), 4'(i)};
            expect_out("init_rd0", K_RD0, 32'd0);
            expect_out("init_rd1", K_RD1, 32'd0);
            expect_out("init_busy0", K_BUSY0, 32'd0);
            cyc_end();
        end

        // Scenario 2: write-through bypass then stored value
        cyc_begin();
        we = 1'b1; waddr = 4'd3; wdata = 16'hBEEF; rd_addr = 8'h03;
        expect_out("bypass_rd0", K_RD0, 32'hBEEF);
        expect_out("bypass_busy0", K_BUSY0, 32'd0);
        cyc_end();
        cyc_begin();
        rd_addr = 8'h30;
        expect_out("stored_rd0", K_RD0, 32'd0);
        expect_out("stored_rd1", K_RD1, 32'hBEEF);
        cyc_end();

        // Scenario 3: reserve R5, reject re-reservation, release by write
        cyc_begin();
        alloc_en = 1'b1; alloc_addr = 4'd5;
        expect_out("alloc5_ok", K_OK, 32'd1);
        expect_out("alloc5_pend_before", K_PEND, 32'd0);
        cyc_end();
        cyc_begin();
        alloc_en = 1'b1; alloc_addr = 4'd5; rd_addr = 8'h05;
        expect_out("alloc5_again_ok", K_OK, 32'd0);
        expect_out("r5_busy", K_BUSY0, 32'd1);
        expect_out("alloc5_pend", K_PEND, 32'd1);
        cyc_end();
        cyc_begin();
        we = 1'b1; waddr = 4'd5; wdata = 16'h1234; rd_addr = 8'h05;
        expect_out("w5_bypass_rd0", K_RD0, 32'h1234);
        expect_out("w5_bypass_busy0", K_BUSY0, 32'd0);
        cyc_end();
        cyc_begin();
        rd_addr = 8'h05;
        expect_out("w5_rd0", K_RD0, 32'h1234);
        expect_out("w5_busy0", K_BUSY0, 32'd0);
        expect_out("w5_pend", K_PEND, 32'd0);
        cyc_end();

        // Scenario 4: busy R7 written and re-reserved in one cycle
        cyc_begin();
        alloc_en = 1'b1; alloc_addr = 4'd7;
        expect_out("alloc7_ok", K_OK, 32'd1);
        cyc_end();
        cyc_begin();
        we = 1'b1; waddr = 4'd7; wdata = 16'hAAAA;
        alloc_en = 1'b1; alloc_addr = 4'd7; rd_addr = 8'h77;
        expect_out("wa7_ok", K_OK, 32'd1);
        expect_out("wa7_rd0", K_RD0, 32'hAAAA);
        expect_out("wa7_busy1", K_BUSY1, 32'd0);
        expect_out("wa7_pend_before", K_PEND, 32'd1);
        cyc_end();
        cyc_begin();
        rd_addr = 8'h07;
        expect_out("r7_rd0", K_RD0, 32'hAAAA);
        expect_out("r7_busy0", K_BUSY0, 32'd1);
        expect_out("r7_pend", K_PEND, 32'd1);
        cyc_end();

        // Reserve R9 while releasing R7: count stays put
        cyc_begin();
        we = 1'b1; waddr = 4'd7; wdata = 16'h0707;
        alloc_en = 1'b1; alloc_addr = 4'd9;
        expect_out("a9w7_ok", K_OK, 32'd1);
        cyc_end();
        cyc_begin();
        rd_addr = 8'h97;
        expect_out("a9w7_busy7", K_BUSY0, 32'd0);
        expect_out("a9w7_busy9", K_BUSY1, 32'd1);
        expect_out("a9w7_pend", K_PEND, 32'd1);
        expect_out("a9w7_rd7", K_RD0, 32'h0707);
        cyc_end();

        // Scenario 5: register 0 is hardwired
        cyc_begin();
        we = 1'b1; waddr = 4'd0; wdata = 16'hFFFF;
        alloc_en = 1'b1; alloc_addr = 4'd0; rd_addr = 8'h00;
        expect_out("r0_ok", K_OK, 32'd0);
        expect_out("r0_bypass", K_RD0, 32'd0);
        expect_out("r0_busy", K_BUSY0, 32'd0);
        cyc_end();
        cyc_begin();
        rd_addr = 8'h00;
        expect_out("r0_rd", K_RD0, 32'd0);
        expect_out("r0_pend", K_PEND, 32'd1);
        cyc_end();

        // Scenario 6: clear with live data and reservations
        cyc_begin();
        we = 1'b1; waddr = 4'd2; wdata = 16'h55AA;
        alloc_en = 1'b1; alloc_addr = 4'd4;
        expect_out("pre_clr_ok", K_OK, 32'd1);
        cyc_end();
        cyc_begin();
        clear = 1'b1; rd_addr = 8'h42;
        expect_out("clr_ready", K_READY, 32'd1);
        expect_out("clr_rd2", K_RD0, 32'h55AA);
        expect_out("clr_busy4", K_BUSY1, 32'd1);
        expect_out("clr_pend", K_PEND, 32'd2);
        cyc_end();
        @(posedge clk);
        #1;
        clear = 1'b0;
        check_eq("clr_ready_low", 32'(ready), 32'd0);
        check_eq("clr_pend_zero", 32'(pend_cnt), 32'd0);
        check_eq("clr_rd_zero", 32'(rd_data), 32'd0);
        wait_ready("clr_sweep_cycles");
        cyc_begin();
        rd_addr = 8'h42;
        expect_out("post_clr_rd2", K_RD0, 32'd0);
        expect_out("post_clr_busy4", K_BUSY1, 32'd0);
        expect_out("post_clr_pend", K_PEND, 32'd0);
        cyc_end();

        // Reset mid-sweep restarts the full sweep
        cyc_begin();
        we = 1'b1; waddr = 4'd3; wdata = 16'hC0DE;
        cyc_end();
        cyc_begin();
        clear = 1'b1;
        cyc_end();
        cyc_begin();
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ready", 32'(ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("midrst_sweep_cycles");
        cyc_begin();
        rd_addr = 8'h93;
        expect_out("midrst_rd3", K_RD0, 32'd0);
        expect_out("midrst_busy9", K_BUSY1, 32'd0);
        expect_out("midrst_pend", K_PEND, 32'd0);
        cyc_end();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 16, meaning entry count (power of 2, >=4); ADDR_W = clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous request to re-zero the whole file.
- ready  out  1  file initialised and accepting operations.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data.
- rd_busy  out  NUM_RD  per-port flag: the addressed register has a pending write.
- alloc_en  in  1  request to reserve a destination register.
- alloc_addr  in  ADDR_W  register to reserve.
- alloc_ok  out  1  the reservation is accepted this cycle.
- pend_cnt  out  ADDR_W+1  number of reserved registers.

Function
REQ-005 SHALL implement an FSM with states INIT and RUN; ready = (state==RUN).
REQ-006 In INIT, the block SHALL write 0 to entry cnt each cycle and increment cnt; after the cycle writing entry NUM_REGS-1 it SHALL enter RUN (exactly NUM_REGS cycles).
REQ-007 clear asserted in RUN SHALL move to INIT with cnt=0 and all busy bits cleared on the next edge; clear asserted in INIT SHALL restart cnt at 0.
REQ-008 While ready=0, the block SHALL ignore we and alloc_en, drive rd_data all-zero, rd_busy all-zero and alloc_ok 0.
REQ-009 Entry 0 SHALL be hardwired: reads return 0, writes are discarded, it is never busy, and alloc to 0 gives alloc_ok=0.
REQ-010 A write (we && ready && waddr!=0) SHALL update the entry at the clock edge and clear busy[waddr].
REQ-011 Reads SHALL be combinational, with zero-cycle latency.
REQ-012 Write-through bypass: when a valid write targets rd_addr[p] in the same cycle, rd_data[p] SHALL be wdata and rd_busy[p] SHALL be 0.
REQ-013 Otherwise rd_busy[p] SHALL be busy[rd_addr[p]].
REQ-014 alloc_ok SHALL be alloc_en && ready && alloc_addr!=0 && (busy[alloc_addr]==0 || a valid write to alloc_addr this cycle); alloc_ok=1 SHALL set busy[alloc_addr] at the edge.
REQ-015 When a write and an alloc target the same register in the same cycle, the entry SHALL take wdata and busy SHALL end at 1 (alloc wins).
REQ-016 pend_cnt SHALL equal the popcount of busy, registered and updated in the same cycle as busy (+1 on alloc, -1 on clearing write, net 0 when both occur); it SHALL never exceed NUM_REGS-1.
REQ-017 A write to a non-busy register SHALL be legal and SHALL leave pend_cnt unchanged.

Reset
REQ-018 On rst_n low, the block SHALL asynchronously set state=INIT, cnt=0, busy=0 and pend_cnt=0; the data array SHALL NOT be reset directly and is zeroed by the INIT sweep.
REQ-019 Reset asserted mid-sweep or mid-RUN SHALL abort the operation; the sweep SHALL restart from entry 0 after rst_n rises.
REQ-020 ready SHALL be 0 during reset and for NUM_REGS cycles after rst_n deasserts.

Structure
REQ-021 The shared cpu package SHALL hold DATA_W and NUM_REGS defaults and the FSM state enum {INIT, RUN}.
REQ-022 The data array SHALL be a single write-port storage that allows RAM inference; the scoreboard (busy vector, pend_cnt, alloc logic) SHALL be the sub-module rf_scoreboard.

Verification
REQ-023 Scenario 1: release rst_n -> ready rises after exactly 16 cycles; all reads return 0x0000.
REQ-024 Scenario 2: in RUN, write R3=0xBEEF while rd_addr0=3 in the same cycle -> rd_data0=0xBEEF that cycle; next cycle still 0xBEEF.
REQ-025 Scenario 3: alloc R5 -> alloc_ok=1 and pend_cnt=1; read R5 -> rd_busy=1; alloc R5 again -> alloc_ok=0; write R5=0x1234 -> rd_busy=0 and pend_cnt=0.
REQ-026 Scenario 4: R7 busy, with a same-cycle write R7=0xAAAA and alloc R7 -> alloc_ok=1, R7=0xAAAA, still busy, pend_cnt unchanged.
REQ-027 Scenario 5: write R0=0xFFFF and alloc R0 -> R0 reads 0 and alloc_ok=0.
REQ-028 Scenario 6: pulse clear with R2=0x55AA and R4 busy -> ready=0 for 16 cycles, then R2=0, pend_cnt=0; rst_n pulsed mid-sweep -> sweep restarts from entry 0.
